// File: rtl/regfile_pkg.sv
// Shared definitions for the eight-entry register file: default widths
// and the register address type used by decode and by users of the block.
package regfile_pkg;

  localparam int DEFAULT_DATA_W = 16;
  localparam int DEFAULT_ADDR_W = 3;
  localparam int DEFAULT_NREGS  = 1 << DEFAULT_ADDR_W;

  typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
  typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/regfile_cell.sv
// One register of the file: a DATA_W flop with asynchronous active-low
// clear and a load enable driven by the top-level write decoder.
module regfile_cell
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/regfile.sv
// Eight-entry 16-bit register file: one synchronous write port and two
// combinational read ports. No write-through bypass; register 0 is writable.
module regfile
  import regfile_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ADDR_W = DEFAULT_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              WEn,
  input  logic [ADDR_W-1:0] WR_addr,
  input  logic [DATA_W-1:0] WR_data,
  input  logic [ADDR_W-1:0] RA_addr,
  input  logic [ADDR_W-1:0] RB_addr,
  output logic [DATA_W-1:0] RA_data,
  output logic [DATA_W-1:0] RB_data
);

  localparam int NREGS = 1 << ADDR_W;

  logic [NREGS-1:0]  write_sel;
  logic [DATA_W-1:0] cell_q [NREGS];

  // One-hot write decode; all zero when WEn is low so no cell loads.
  always_comb begin
    write_sel = '0;
    if (WEn) begin
      write_sel[WR_addr] = 1'b1;
    end
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    regfile_cell #(
      .DATA_W (DATA_W)
    ) u_cell (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (write_sel[i]),
      .d     (WR_data),
      .q     (cell_q[i])
    );
  end

  // Read muxes see only the flop outputs, so a same-cycle write shows after the edge.
  assign RA_data = cell_q[RA_addr];
  assign RB_data = cell_q[RB_addr];

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed vector table, hand-written
// reset/fill sequences, and randomized traffic against an array model.
module tb_regfile;
  import regfile_pkg::*;

  logic      clk;
  logic      rst_n;
  logic      wen;
  reg_addr_t wr_addr;
  reg_data_t wr_data;
  reg_addr_t ra_addr;
  reg_addr_t rb_addr;
  reg_data_t ra_data;
  reg_data_t rb_data;

  int checks = 0;
  int errors = 0;

  reg_data_t model [8];

  typedef struct {
    logic      wen;
    reg_addr_t wr_addr;
    reg_data_t wr_data;
    reg_addr_t ra_addr;
    reg_addr_t rb_addr;
    reg_data_t exp_a;
    reg_data_t exp_b;
  } vec_t;

  vec_t vecs [10];

  regfile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .WEn     (wen),
    .WR_addr (wr_addr),
    .WR_data (wr_data),
    .RA_addr (ra_addr),
    .RB_addr (rb_addr),
    .RA_data (ra_data),
    .RB_data (rb_data)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input reg_data_t act, input reg_data_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Sweep both ports over all addresses; expected is 0 or 16'h1000+addr.
  task automatic sweep(input string tag, input bit filled);
    reg_data_t exp_a;
    reg_data_t exp_b;
    for (int i = 0; i < 8; i++) begin
      ra_addr = reg_addr_t'(i);
      rb_addr = reg_addr_t'(7 - i);
      #1;
      exp_a = filled ? reg_data_t'(16'h1000 + i) : 16'h0000;
      exp_b = filled ? reg_data_t'(16'h1000 + 7 - i) : 16'h0000;
      check($sformatf("%s_a[%0d]", tag, i), ra_data, exp_a);
      check($sformatf("%s_b[%0d]", tag, 7 - i), rb_data, exp_b);
    end
  endtask

  task automatic write_reg(input reg_addr_t a, input reg_data_t d);
    @(negedge clk);
    wen = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wen = 1'b0;
  endtask

  initial begin
    // Directed table; exp_a/exp_b are the reads just before each row's edge.
    vecs[0] = '{1'b1, 3'd0, 16'hABCD, 3'd0, 3'd1, 16'h0000, 16'h0000};
    vecs[1] = '{1'b1, 3'd1, 16'h0123, 3'd0, 3'd1, 16'hABCD, 16'h0000};
    vecs[2] = '{1'b0, 3'd2, 16'hFFFF, 3'd0, 3'd1, 16'hABCD, 16'h0123};
    vecs[3] = '{1'b0, 3'd2, 16'hFFFF, 3'd2, 3'd2, 16'h0000, 16'h0000};
    vecs[4] = '{1'b0, 3'd2, 16'hFFFF, 3'd2, 3'd0, 16'h0000, 16'hABCD};
    vecs[5] = '{1'b1, 3'd3, 16'h1111, 3'd3, 3'd2, 16'h0000, 16'h0000};
    vecs[6] = '{1'b1, 3'd3, 16'h2222, 3'd3, 3'd3, 16'h1111, 16'h1111};
    vecs[7] = '{1'b1, 3'd5, 16'h5A5A, 3'd3, 3'd5, 16'h2222, 16'h0000};
    vecs[8] = '{1'b0, 3'd5, 16'h0000, 3'd5, 3'd5, 16'h5A5A, 16'h5A5A};
    vecs[9] = '{1'b0, 3'd0, 16'h0000, 3'd7, 3'd4, 16'h0000, 16'h0000};

    rst_n = 1'b0; wen = 1'b0; wr_addr = '0; wr_data = '0; ra_addr = '0; rb_addr = '0;

    // Reset held: outputs zero during reset, and after release.
    repeat (3) @(posedge clk);
    @(negedge clk);
    sweep("in_reset", 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    sweep("post_reset", 1'b0);

    // Directed vector table.
    for (int v = 0; v < 10; v++) begin
      @(negedge clk);
      wen = vecs[v].wen; wr_addr = vecs[v].wr_addr; wr_data = vecs[v].wr_data;
      ra_addr = vecs[v].ra_addr; rb_addr = vecs[v].rb_addr;
      #1;
      check($sformatf("vec%0d_a", v), ra_data, vecs[v].exp_a);
      check($sformatf("vec%0d_b", v), rb_data, vecs[v].exp_b);
    end
    @(negedge clk);
    wen = 1'b0;
    ra_addr = 3'd3;
    #1;
    check("rdw_after_edge", ra_data, 16'h2222);

    // Fill all registers with 16'h1000+i and sweep.
    for (int i = 0; i < 8; i++) write_reg(reg_addr_t'(i), reg_data_t'(16'h1000 + i));
    @(negedge clk);
    sweep("fill", 1'b1);

    // Mid-cycle reset pulse clears asynchronously.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    sweep("async_rst", 1'b0);

    // Write presented while reset is held: reset wins.
    @(negedge clk);
    wen = 1'b1; wr_addr = 3'd6; wr_data = 16'hBEEF; ra_addr = 3'd6;
    @(posedge clk);
    #1;
    check("reset_wins", ra_data, 16'h0000);
    @(negedge clk);
    #2;
    rst_n = 1'b1;
    #1;
    check("release_no_write_yet", ra_data, 16'h0000);
    @(posedge clk);
    #1;
    check("first_write_after_release", ra_data, 16'hBEEF);
    wen = 1'b0;

    // Randomized traffic against the array model.
    for (int i = 0; i < 8; i++) model[i] = 16'h0000;
    model[6] = 16'hBEEF;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      wen     = 1'($urandom_range(0, 1));
      wr_addr = reg_addr_t'($urandom_range(0, 7));
      wr_data = reg_data_t'($urandom);
      ra_addr = reg_addr_t'($urandom_range(0, 7));
      rb_addr = ($urandom_range(0, 3) == 0) ? wr_addr : reg_addr_t'($urandom_range(0, 7));
      #1;
      check("rand_a", ra_data, model[ra_addr]);
      check("rand_b", rb_data, model[rb_addr]);
      ra_addr = reg_addr_t'($urandom_range(0, 7));
      #1;
      check("rand_a_readdr", ra_data, model[ra_addr]);
      @(posedge clk);
      if (wen) model[wr_addr] = wr_data;
    end
    @(negedge clk);
    wen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ra_addr = reg_addr_t'(i);
      #1;
      check($sformatf("rand_final[%0d]", i), ra_data, model[i]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
